alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A three-state controller (IDLE -> EXEC -> RESP) accepts one operation at a
// time, drives the ALU from registers, captures its result and holds it on a
// valid/ready response port until it is accepted.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it requester 0 has fixed priority and no pointer register exists.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  // requester 0
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  output logic        req0_ready,
  // requester 1
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        req1_ready,
  // shared ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_ainvert,
  output logic        alu_binvert,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Op code layout is {ainvert, binvert, alu_op[1:0]}; only six combinations
  // are meaningful operations, everything else is reported as an error.
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: is_legal = 1'b1;
      default:                                              is_legal = 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        ainv_q, binv_q;
  logic        id_q, err_q;
  logic [31:0] rsp_result_q;
  logic        rsp_zero_q;

  logic        grant_id;
  logic        grant_fire;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic rr_ptr_q;

  // Winner selection: the pointed-to requester wins a tie, a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = rr_ptr_q;
    else                          grant_id = req1_valid;
  end

  // Pointer moves to the requester that did not win, so ties alternate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           rr_ptr_q <= 1'b0;
    else if (grant_fire) rr_ptr_q <= ~grant_id;
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is not asking.
  always_comb begin
    grant_id = ~req0_valid;
  end
`endif

  // A grant happens only in IDLE; reset also masks it so ready stays low while reset is held.
  assign grant_fire = (state_q == S_IDLE) && (req0_valid || req1_valid) && !reset;

  // Operand mux from the winning requester.
  always_comb begin
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
    sel_op = grant_id ? req1_op : req0_op;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_fire) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: one-cycle ready pulse to the winner in IDLE, rsp_valid only in RESP.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = grant_fire && !grant_id;
        req1_ready = grant_fire &&  grant_id;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture on grant, result capture on the EXEC->RESP edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 2'b00;
      ainv_q       <= 1'b0;
      binv_q       <= 1'b0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (grant_fire) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= grant_id;
        err_q <= !is_legal(sel_op);
        // Illegal codes run as a plain AND so the ALU sees a harmless operation.
        if (is_legal(sel_op)) begin
          ainv_q <= sel_op[3];
          binv_q <= sel_op[2];
          op_q   <= sel_op[1:0];
        end else begin
          ainv_q <= 1'b0;
          binv_q <= 1'b0;
          op_q   <= 2'b00;
        end
      end
      if (state_q == S_EXEC) begin
        rsp_result_q <= err_q ? '0 : alu_result;
        rsp_zero_q   <= err_q | alu_zero;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_ainvert = ainv_q;
  assign alu_binvert = binv_q;

  assign rsp_id      = id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed self-checking bench for alu_arbiter.
// A behavioural ALU sits on the ALU port; expected responses come from a
// plain-arithmetic reference of the op codes and the arbitration rules.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_ainvert, alu_binvert, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_ainvert(alu_ainvert),
    .alu_binvert(alu_binvert),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  // Behavioural one-bit-slice style ALU: invert inputs, carry-in = binvert.
  logic [31:0] s_a, s_b, s_sum, s_res;
  logic        s_ovf;
  always_comb begin
    s_a   = alu_ainvert ? ~alu_a : alu_a;
    s_b   = alu_binvert ? ~alu_b : alu_b;
    s_sum = s_a + s_b + {31'b0, alu_binvert};
    s_ovf = (s_a[31] == s_b[31]) && (s_sum[31] != s_a[31]);
    case (alu_op)
      2'b00:   s_res = s_a & s_b;
      2'b01:   s_res = s_a | s_b;
      2'b10:   s_res = s_sum;
      default: s_res = {31'b0, s_sum[31] ^ s_ovf};
    endcase
    alu_result = s_res;
    alu_zero   = (s_res == 32'd0);
  end

  // Reference meaning of each op code; ctrl is what the ALU port must show in EXEC.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                 output logic [31:0] r, output logic z, output logic e,
                                 output logic [3:0] ctrl);
    e    = 1'b0;
    ctrl = op;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: begin r = 32'd0; e = 1'b1; ctrl = 4'b0000; end
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic drive_req(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  task automatic clear_req(input bit id);
    if (!id) req0_valid = 1'b0;
    else     req1_valid = 1'b0;
  endtask

  // One isolated operation; holds rsp_ready low for 'stall' extra RESP cycles.
  task automatic run_single(input bit id, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input int stall);
    logic [31:0] e_r;
    logic        e_z, e_e;
    logic [3:0]  e_ctrl;
    logic [1:0]  e_rdy;
    ref_op(a, b, op, e_r, e_z, e_e, e_ctrl);
    e_rdy = id ? 2'b10 : 2'b01;
    @(negedge clk);
    rsp_ready = (stall == 0);
    drive_req(id, a, b, op);
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== e_rdy) begin
      n_fail++;
      $display("FAIL grant_pulse: ready={%b,%b} expected %b", req1_ready, req0_ready, e_rdy);
    end
    @(posedge clk);
    #1 clear_req(id);
    @(negedge clk); // EXEC
    n_checks++;
    if ({rsp_valid, req1_ready, req0_ready, alu_a, alu_b, alu_ainvert, alu_binvert, alu_op} !==
        {3'b000, a, b, e_ctrl}) begin
      n_fail++;
      $display("FAIL exec_drive: valid=%b rdy=%b%b a=%h b=%h ctrl=%b%b%b expected a=%h b=%h ctrl=%b",
               rsp_valid, req1_ready, req0_ready, alu_a, alu_b, alu_ainvert, alu_binvert, alu_op,
               a, b, e_ctrl);
    end
    @(negedge clk); // RESP
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, id, e_r, e_z, e_e}) begin
      n_fail++;
      $display("FAIL response: valid=%b id=%b res=%h z=%b err=%b expected id=%b res=%h z=%b err=%b",
               rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, id, e_r, e_z, e_e);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, id, e_r, e_z, e_e}) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d valid=%b res=%h expected res=%h", s, rsp_valid, rsp_result, e_r);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_drop: rsp_valid=%b expected 0 after handshake", rsp_valid);
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h1234_5678; req0_op = 4'b0010;
    req1_a = 32'hA5A5_A5A5; req1_b = 32'h5A5A_5A5A; req1_op = 4'b0001;
    #2;
    n_checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: rdy=%b%b valid=%b id=%b res=%h z=%b err=%b expected all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op, alu_ainvert, alu_binvert} !== '0) begin
      n_fail++;
      $display("FAIL reset_alu: a=%h b=%h op=%b ai=%b bi=%b expected all 0",
               alu_a, alu_b, alu_op, alu_ainvert, alu_binvert);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_add_single();
    run_single(1'b0, 32'd5, 32'd3, 4'b0010, 0); // expect 8, zero 0
  endtask

  task automatic test_sub_slt();
    run_single(1'b1, 32'd7, 32'd7, 4'b0110, 0); // expect 0, zero 1
    run_single(1'b1, 32'd2, 32'd9, 4'b0111, 0); // expect 1
    run_single(1'b0, 32'hFFFF_FFFE, 32'd3, 4'b0111, 0); // signed -2 < 3
    run_single(1'b1, 32'h0F0F_0000, 32'h0000_00F0, 4'b1100, 0);
  endtask

  task automatic test_illegal();
    run_single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 0);
    run_single(1'b1, 32'h1234_5678, 32'h0000_0001, 4'b1111, 1);
  endtask

  // Both requesters held valid with rsp_ready high: grant order per arbitration policy.
  task automatic test_arbitration();
    bit          found, exp_id;
    logic [31:0] e_r;
    logic        e_z, e_e;
    logic [3:0]  e_ctrl;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(1'b0, 32'd10, 32'd4, 4'b0010);
    drive_req(1'b1, 32'd10, 32'd4, 4'b0110);
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        #1;
        if (req0_ready || req1_ready) found = 1'b1;
        else @(negedge clk);
      end
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL arb_timeout: no grant for operation %0d", k);
      end else if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL arb_order: op %0d ready={%b,%b} expected winner %0d", k, req1_ready, req0_ready, exp_id);
      end
      ref_op(32'd10, 32'd4, exp_id ? 4'b0110 : 4'b0010, e_r, e_z, e_e, e_ctrl);
      @(negedge clk); // EXEC
      @(negedge clk); // RESP
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== {1'b1, exp_id, e_r, e_e}) begin
        n_fail++;
        $display("FAIL arb_rsp: op %0d valid=%b id=%b res=%h expected id=%b res=%h",
                 k, rsp_valid, rsp_id, rsp_result, exp_id, e_r);
      end
      @(negedge clk); // back in IDLE
    end
    clear_req(1'b0);
    clear_req(1'b1);
    @(negedge clk);
  endtask

  // Response stalled 5 cycles with requester 1 waiting; no ready until IDLE again.
  task automatic test_stall();
    bit ok;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(1'b0, 32'h8000_0000, 32'h8000_0000, 4'b0010); // wraps to 0
    @(posedge clk);
    #1 clear_req(1'b0);
    drive_req(1'b1, 32'd1, 32'd2, 4'b0001);
    @(negedge clk); // EXEC
    @(negedge clk); // RESP
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req0_ready, req1_ready} !==
          {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL stall: cycle %0d valid=%b id=%b res=%h z=%b err=%b rdy=%b%b",
                 s, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL handshake_cycle: valid=%b req1_ready=%b expected 1,0", rsp_valid, req1_ready);
    end
    @(negedge clk); // IDLE: waiting requester now granted
    ok = (rsp_valid === 1'b0) && (req1_ready === 1'b1);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL resume: valid=%b req1_ready=%b expected 0,1", rsp_valid, req1_ready);
    end
    @(posedge clk);
    #1 clear_req(1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(1'b0, 32'd100, 32'd23, 4'b0010);
    @(posedge clk);
    #1 clear_req(1'b0);
    drive_req(1'b1, 32'd3, 32'd4, 4'b0010);
    @(negedge clk); // EXEC
    n_checks++;
    if (alu_a !== 32'd100) begin
      n_fail++;
      $display("FAIL pre_reset_exec: alu_a=%h expected %h", alu_a, 32'd100);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
         alu_a, alu_b, alu_op, alu_ainvert, alu_binvert} !== '0) begin
      n_fail++;
      $display("FAIL mid_exec_reset: rdy=%b%b valid=%b res=%h a=%h b=%h op=%b expected all 0",
               req0_ready, req1_ready, rsp_valid, rsp_result, alu_a, alu_b, alu_op);
    end
    clear_req(1'b1);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abandoned_rsp: rsp_valid=1 observed expected 0 after reset");
    end
    run_single(1'b0, 32'd40, 32'd2, 4'b0010, 0);
  endtask

  task automatic test_random();
    logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [3:0] op;
    bit         id;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else                           op = legal_ops[$urandom_range(0, 5)];
      id = 1'($urandom_range(0, 1));
      run_single(id, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, op,
                 int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    test_reset();
    test_add_single();
    test_sub_slt();
    test_illegal();
    test_arbitration();
    test_stall();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
